// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, oversampling constants,
// RX/TX state types and the frame parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // Parity bit to transmit / expect for a payload (zero-extended to 8 bits).
  function automatic logic calc_parity(input logic [7:0] d, input int mode);
    logic p;
    p = ^d;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head (first-word fall-through).
// Push and pop may share a cycle; a push into a full FIFO is accepted only
// when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_nxt;
  logic [AW:0]      w_level_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_pop_ok    = i_pop & ~w_empty;
  assign w_push_ok   = i_push & (~w_full | w_pop_ok);
  assign w_rd_nxt    = r_rd_ptr + AW'(w_pop_ok);
  assign w_level_nxt = r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
  // New head bypasses the array when the written slot becomes the head.
  assign w_head_nxt  = (w_push_ok && (r_wr_ptr == w_rd_nxt)) ? i_push_data : r_mem[w_rd_nxt];

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers, level and registered head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_head   <= (w_level_nxt == '0) ? '0 : w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_valid = ~w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/uart_fifo_ctl.sv
// Parametrised UART: 16x oversampling receiver and transmitter, each
// buffered by a uart_sync_fifo. Optional CTS/RTS flow control is built in
// when the macro UART_FLOW_CTL_EN is defined.
// Core-side handshakes: a transfer happens in every cycle where valid and
// ready are both high; valid never waits for ready, and the data is stable
// while valid is high and ready is low.
module uart_fifo_ctl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV        = 27,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovr,
`ifdef UART_FLOW_CTL_EN
  input  logic                 cts_n,
  output logic                 rts_n,
`endif
  output rx_state_t            o_dbg_rx_state,
  output tx_state_t            o_dbg_tx_state
);
  localparam int TW = $clog2(DIV);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- tick generator ----------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  // Free-running oversample divider shared by RX and TX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // ---------------- FIFOs ----------------
  logic [DATA_BITS+1:0] w_rx_head;
  logic [DATA_BITS+1:0] w_rx_entry;
  logic [LW-1:0]        w_rx_level;
  logic                 w_rx_push;
  logic                 w_rx_full;
  logic                 w_rx_ferr;
  logic [DATA_BITS-1:0] w_tx_head;
  logic [LW-1:0]        w_tx_level;
  logic                 w_tx_avail;
  logic                 w_tx_pop;
  logic                 w_tx_go;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(clk), .i_rst_n(rst),
    .i_push(tx_valid & tx_ready), .i_push_data(tx_data), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_valid(w_tx_avail), .o_level(w_tx_level)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(clk), .i_rst_n(rst),
    .i_push(w_rx_push), .i_push_data(w_rx_entry), .i_pop(rx_ready),
    .o_head(w_rx_head), .o_valid(rx_valid), .o_level(w_rx_level)
  );

  assign tx_ready  = (w_tx_level != LW'(FIFO_DEPTH));
  assign w_rx_full = (w_rx_level == LW'(FIFO_DEPTH));
  assign rx_data   = w_rx_head[DATA_BITS-1:0];
  assign rx_ferr   = w_rx_head[DATA_BITS];
  assign rx_perr   = w_rx_head[DATA_BITS+1];

  // ---------------- RX ----------------
  logic                 r_rx_meta, r_rx_sync;
  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [3:0]           r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]           r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
  logic                 r_rx_perr, w_rx_perr_nxt;
  logic                 r_rx_wait, w_rx_wait_nxt;
  logic                 r_rx_ovr;
  logic                 w_rx_last;

  assign w_rx_last  = w_tick && (r_rx_cnt == 4'(OVERSAMPLE - 1));
  assign w_rx_entry = {r_rx_perr, w_rx_ferr, r_rx_shift};

  // Receiver state and datapath registers; rx enters via a 2-flop synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_wait  <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_perr  <= w_rx_perr_nxt;
      r_rx_wait  <= w_rx_wait_nxt;
    end
  end

  // Receiver next state: start qualified at mid-bit, later bits every 16 ticks.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_wait_nxt  = r_rx_wait;
    w_rx_push      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_wait) begin
          if (r_rx_sync) w_rx_wait_nxt = 1'b0;
        end else if (w_tick && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_cnt == 4'(MID_SAMPLE)) begin
            w_rx_cnt_nxt   = '0;
            w_rx_bit_nxt   = '0;
            w_rx_perr_nxt  = 1'b0;
            w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          w_rx_bit_nxt   = r_rx_bit + 1'b1;
          if (r_rx_bit == 3'(DATA_BITS - 1))
            w_rx_state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end else if (w_tick) begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_perr_nxt  = (r_rx_sync != calc_parity(8'(r_rx_shift), PARITY));
          w_rx_state_nxt = RX_STOP;
        end else if (w_tick) begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (w_rx_last) begin
          w_rx_push      = 1'b1;
          w_rx_ferr      = ~r_rx_sync;
          w_rx_cnt_nxt   = '0;
          w_rx_wait_nxt  = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end else if (w_tick) begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Sticky overrun: set when a frame is dropped on a full FIFO, cleared by a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          r_rx_ovr <= 1'b0;
    else if (w_rx_push && w_rx_full && !rx_ready)      r_rx_ovr <= 1'b1;
    else if (rx_valid && rx_ready)                     r_rx_ovr <= 1'b0;
  end
  assign rx_ovr = r_rx_ovr;

  // ---------------- flow control ----------------
`ifdef UART_FLOW_CTL_EN
  logic r_cts_meta, r_cts_sync, r_rts_n;

  // CTS synchroniser and registered RTS threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
      r_rts_n    <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
      r_rts_n    <= (w_rx_level >= LW'(FIFO_DEPTH - 2));
    end
  end
  assign rts_n   = r_rts_n;
  assign w_tx_go = w_tx_avail & ~r_cts_sync;
`else
  assign w_tx_go = w_tx_avail;
`endif

  // ---------------- TX ----------------
  tx_state_t            r_tx_state, w_tx_state_nxt;
  logic [3:0]           r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]           r_tx_bit, w_tx_bit_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
  logic                 r_tx_par, w_tx_par_nxt;
  logic                 w_tx_last;

  assign w_tx_last = w_tick && (r_tx_cnt == 4'(OVERSAMPLE - 1));

  // Transmitter state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
    end
  end

  // Transmitter next state and line level; the stop phase chains straight
  // into the next start bit when another byte is waiting.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_tx_pop       = 1'b0;
    tx             = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tick && w_tx_go) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_head;
          w_tx_par_nxt   = calc_parity(8'(w_tx_head), PARITY);
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (w_tx_last) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else if (w_tick) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx = r_tx_shift[0];
        if (w_tx_last) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = r_tx_shift >> 1;
          w_tx_bit_nxt   = r_tx_bit + 1'b1;
          if (r_tx_bit == 3'(DATA_BITS - 1)) begin
            w_tx_bit_nxt   = '0;
            w_tx_state_nxt = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
          end
        end else if (w_tick) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_PARITY: begin
        tx = r_tx_par;
        if (w_tx_last) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_STOP;
        end else if (w_tick) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tx_last) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'(STOP_BITS - 1)) begin
            if (w_tx_go) begin
              w_tx_pop       = 1'b1;
              w_tx_shift_nxt = w_tx_head;
              w_tx_par_nxt   = calc_parity(8'(w_tx_head), PARITY);
              w_tx_state_nxt = TX_START;
            end else begin
              w_tx_state_nxt = TX_IDLE;
            end
          end else begin
            w_tx_bit_nxt = r_tx_bit + 1'b1;
          end
        end else if (w_tick) begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign o_dbg_rx_state = r_rx_state;
  assign o_dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Bench for uart_fifo_ctl configured 8E1, DIV=4 (64 clk per bit), FIFO_DEPTH=4.
module tb_uart_fifo_ctl;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_drv;
  logic       loop_en;
  logic       rx_line;
  logic       tx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_ovr;
  rx_state_t  dbg_rx;
  tx_state_t  dbg_tx;
`ifdef UART_FLOW_CTL_EN
  logic       rts_n;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo_ctl #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst_n), .rx(rx_line), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovr(rx_ovr),
`ifdef UART_FLOW_CTL_EN
    .cts_n(1'b0), .rts_n(rts_n),
`endif
    .o_dbg_rx_state(dbg_rx), .o_dbg_tx_state(dbg_tx)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference frame, bit 0 first on the line: start, LSB-first data,
  // even parity (optionally corrupted), stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic flip, input logic stop_v);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 1) ^ flip;
    f[10] = stop_v;
    return f;
  endfunction

  // driver: push one byte into the TX FIFO
  task automatic push(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick_clk(1);
    end
    chk("push_accepted", 32'(ok), 32'd1);
    tick_clk(1);
    tx_valid = 1'b0;
  endtask

  // driver: put one frame on the rx pin, then idle for two bit times
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_v);
    logic [10:0] f;
    f = frame_of(d, flip, stop_v);
    for (int k = 0; k < 11; k++) begin
      rx_drv = f[k];
      tick_clk(BIT_CLK);
    end
    rx_drv = 1'b1;
    tick_clk(2 * BIT_CLK);
  endtask

  task automatic wait_tx_fall(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick_clk(1);
    end
  endtask

  // scoreboard: pop n RX entries and compare each against exp_q
  task automatic collect(input int n, input int budget);
    int got;
    logic [9:0] e;
    got = 0;
    rx_ready = 1'b1;
    for (int i = 0; i < budget && got < n; i++) begin
      if (rx_valid) begin
        e = exp_q.pop_front();
        chk("rx_entry", 32'({rx_perr, rx_ferr, rx_data}), 32'(e));
        got++;
      end
      tick_clk(1);
    end
    rx_ready = 1'b0;
    chk("rx_entry_count", 32'(got), 32'(n));
  endtask

  initial begin
    logic        ok;
    logic [10:0] f;
    logic [7:0]  d;
    int          n;

    // reset
    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    tick_clk(5);
    rst_n = 1'b1;
    tick_clk(1);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_flags", 32'({rx_perr, rx_ferr, rx_ovr}), 32'd0);
    chk("rst_rx_state", 32'(dbg_rx), 32'(RX_IDLE));
    chk("rst_tx_state", 32'(dbg_tx), 32'(TX_IDLE));

    // TX waveform of 0xA5, bit-exact durations
    push(8'hA5);
    wait_tx_fall(20, ok);
    chk("tx_start_seen", 32'(ok), 32'd1);
    f = frame_of(8'hA5, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      tick_clk(1);
      chk($sformatf("tx_bit%0d_early", k), 32'(tx), 32'(f[k]));
      tick_clk(31);
      chk("tx_ready_in_frame", 32'(tx_ready), 32'd1);
      tick_clk(31);
      chk($sformatf("tx_bit%0d_late", k), 32'(tx), 32'(f[k]));
      tick_clk(1);
    end
    chk("tx_idle_after", 32'(tx), 32'd1);

    // loopback: directed then random bytes
    loop_en = 1'b1;
    tick_clk(BIT_CLK);
    foreach (f[i]) ;
    exp_q.push_back({2'b00, 8'h00}); push(8'h00);
    exp_q.push_back({2'b00, 8'hFF}); push(8'hFF);
    exp_q.push_back({2'b00, 8'h3C}); push(8'h3C);
    collect(3, 5000);
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back({2'b00, d});
      push(d);
    end
    collect(3, 5000);

    // TX FIFO fill: tx_ready drops, then frames leave back to back
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (!tx_ready) break;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back({2'b00, d});
      push(d);
      n++;
    end
    chk("tx_ready_low_when_full", 32'(tx_ready), 32'd0);
    chk("tx_full_push_count", 32'(n >= 4 && n <= 5), 32'd1);
    d = 8'($urandom_range(0, 255));
    exp_q.push_back({2'b00, d});
    push(d);
    collect(n + 1, 9000);
    chk("no_ovr_loopback", 32'(rx_ovr), 32'd0);
    tick_clk(2 * BIT_CLK);
    loop_en = 1'b0;
    tick_clk(2 * BIT_CLK);

    // glitch on rx shorter than half a bit
    rx_drv = 1'b0;
    tick_clk(20);
    rx_drv = 1'b1;
    tick_clk(200);
    chk("glitch_no_entry", 32'(rx_valid), 32'd0);
    chk("glitch_rx_idle", 32'(dbg_rx), 32'(RX_IDLE));

    // bad parity + framing error, then random frames
    send_frame(8'h55, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 1'b1, 8'h55});
    collect(1, 300);
    for (int i = 0; i < 4; i++) begin
      logic flip, stop_v;
      d      = 8'($urandom_range(0, 255));
      flip   = 1'($urandom_range(0, 1));
      stop_v = 1'($urandom_range(0, 1));
      send_frame(d, flip, stop_v);
      exp_q.push_back({flip, ~stop_v, d});
      collect(1, 300);
    end

    // overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b0, 1'b1);
      if (i < 4) exp_q.push_back({2'b00, d});
      if (i == 3) chk("ovr_clear_at_four", 32'(rx_ovr), 32'd0);
    end
    chk("ovr_set", 32'(rx_ovr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_kept_entry", 32'({rx_valid, rx_perr, rx_ferr, rx_data}), 32'({1'b1, exp_q.pop_front()}));
      rx_ready = 1'b1;
      tick_clk(1);
      rx_ready = 1'b0;
      if (i == 0) chk("ovr_cleared_by_pop", 32'(rx_ovr), 32'd0);
    end
    chk("ovr_drained", 32'(rx_valid), 32'd0);

    // asynchronous reset in the middle of a TX data bit
    push(8'h00);
    wait_tx_fall(20, ok);
    chk("rst_test_start_seen", 32'(ok), 32'd1);
    tick_clk(3 * BIT_CLK + 10);
    chk("tx_mid_data_low", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("tx_high_async_rst", 32'(tx), 32'd1);
    tick_clk(3);
    rst_n = 1'b1;
    tick_clk(1);
    chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("post_rst_tx_state", 32'(dbg_tx), 32'(TX_IDLE));
    tick_clk(3 * BIT_CLK);
    chk("post_rst_tx_idle", 32'(tx), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
